// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - load/store unit memory stage, single outstanding dmem request
module lsu_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      mem_op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            done,
  output logic            load_we,
  output logic [XLEN-1:0] load_data,
  output logic [4:0]      rd_out,
  output logic            misalign,
  output logic            illegal,
  output logic            busy
);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_LB   = 4'b0001;
  localparam logic [3:0] OP_LH   = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_LBU  = 4'b0100;
  localparam logic [3:0] OP_LHU  = 4'b0101;
  localparam logic [3:0] OP_SB   = 4'b1110;
  localparam logic [3:0] OP_SH   = 4'b1111;
  localparam logic [3:0] OP_SW   = 4'b1000;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_next;

  logic            op_legal, op_store, misaligned, fault, start;
  logic [3:0]      fmt_mask;
  logic [XLEN-1:0] fmt_data;
  logic [3:0]      op_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    op_legal   = 1'b1;
    op_store   = 1'b0;
    misaligned = 1'b0;
    fmt_mask   = 4'b0000;
    fmt_data   = '0;
    case (mem_op)
      OP_NONE, OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: misaligned = addr[0];
      OP_LW:         misaligned = |addr[1:0];
      OP_SB: begin
        op_store = 1'b1;
        fmt_mask = 4'b0001 << addr[1:0];
        fmt_data = {4{store_data[7:0]}};
      end
      OP_SH: begin
        op_store   = 1'b1;
        misaligned = addr[0];
        fmt_mask   = addr[1] ? 4'b1100 : 4'b0011;
        fmt_data   = {2{store_data[15:0]}};
      end
      OP_SW: begin
        op_store   = 1'b1;
        misaligned = |addr[1:0];
        fmt_mask   = 4'b1111;
        fmt_data   = store_data;
      end
      default: op_legal = 1'b0;
    endcase
  end

  assign fault = !op_legal || misaligned;
  assign start = in_valid && (mem_op != OP_NONE);

  // Stores fall into the default arm, so their completion reports zero load data.
  always_comb begin
    byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      OP_LH:   load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
      OP_LW:   load_ext = dmem_rdata;
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = fault ? RESP : REQ;
      REQ:     if (dmem_ack) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wmask <= 4'b0000;
      dmem_wdata <= '0;
      done       <= 1'b0;
      load_we    <= 1'b0;
      load_data  <= '0;
      rd_out     <= 5'd0;
      misalign   <= 1'b0;
      illegal    <= 1'b0;
      op_q       <= OP_NONE;
      off_q      <= 2'b00;
      rd_q       <= 5'd0;
    end else begin
      done     <= 1'b0;
      load_we  <= 1'b0;
      misalign <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= mem_op;
          off_q <= addr[1:0];
          rd_q  <= rd_in;
          if (fault) begin
            done      <= 1'b1;
            illegal   <= !op_legal;
            misalign  <= op_legal;
            load_data <= '0;
            rd_out    <= rd_in;
          end else begin
            dmem_req   <= 1'b1;
            dmem_we    <= op_store;
            dmem_addr  <= {addr[XLEN-1:2], 2'b00};
            dmem_wmask <= fmt_mask;
            dmem_wdata <= fmt_data;
          end
        end
        REQ: if (dmem_ack) begin
          dmem_req  <= 1'b0;
          done      <= 1'b1;
          load_we   <= !dmem_we;
          load_data <= load_ext;
          rd_out    <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule
